// File: rtl/conv_loop_sequencer.sv
// conv_loop_sequencer
//   Runtime-configurable loop-nest sequencer for the convolution datapath.
//   Walks the tiled output loops (of_t, oy_t, ox_t) and the accumulated loops
//   (ni, ky, kx), outer to inner. It issues one address/control beat per
//   out_valid && out_ready handshake to the input-FM buffer, the weight buffer
//   and a POF x POY x POX MAC array.
//
//   Optional build macro: ZERO_PAD_EN. It adds cfg_pad handling and the pad_zero
//   output. Without the macro, cfg_pad is ignored and there is no pad_zero port.
//
//   Ports
//     clk, rst_n              clock, asynchronous active-low reset
//     start                   pulse in IDLE: latch cfg_* and begin a layer
//     cfg_nif..cfg_s          layer dimensions and stride (DIM_W each)
//     cfg_pad                 zero-padding amount (ZERO_PAD_EN only)
//     busy                    high from accepted start until done
//     done, cfg_err           one-cycle end-of-layer pulse, config-rejected flag
//     out_valid, out_ready    beat handshake
//     ifm_addr, wgt_addr,     buffer addresses of the current beat
//     ofm_addr
//     acc_first, acc_last     MAC load / MAC writeback markers
//     lane_ox/oy/of           valid lanes in the current (possibly edge) tile
//     pad_zero                beat falls outside the unpadded map (ZERO_PAD_EN)
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | waiting for start; config is latched on start
//   S_CHECK | one cycle to validate config and preload the first beat
//   S_RUN   | beats valid; counters advance on each accepted handshake
//   S_DONE  | one-cycle done pulse (cfg_err high with it if rejected)
module conv_loop_sequencer #(
  parameter int DIM_W  = 8,
  parameter int ADDR_W = 16,
  parameter int POF    = 8,
  parameter int POY    = 14,
  parameter int POX    = 14
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [DIM_W-1:0]           cfg_nif,
  input  logic [DIM_W-1:0]           cfg_nof,
  input  logic [DIM_W-1:0]           cfg_nox,
  input  logic [DIM_W-1:0]           cfg_noy,
  input  logic [DIM_W-1:0]           cfg_nix,
  input  logic [DIM_W-1:0]           cfg_nkx,
  input  logic [DIM_W-1:0]           cfg_nky,
  input  logic [DIM_W-1:0]           cfg_s,
  input  logic [DIM_W-1:0]           cfg_pad,
  output logic                       busy,
  output logic                       done,
  output logic                       cfg_err,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_W-1:0]          ifm_addr,
  output logic [ADDR_W-1:0]          wgt_addr,
  output logic [ADDR_W-1:0]          ofm_addr,
  output logic                       acc_first,
  output logic                       acc_last,
  output logic [$clog2(POX+1)-1:0]   lane_ox,
  output logic [$clog2(POY+1)-1:0]   lane_oy,
  output logic [$clog2(POF+1)-1:0]   lane_of
`ifdef ZERO_PAD_EN
  ,
  output logic                       pad_zero
`endif
);

  // Intermediates are wide enough that no partial product wraps before the
  // final truncation to ADDR_W.
  localparam int WIDE = 2*DIM_W + ADDR_W;
  localparam int LXW  = $clog2(POX+1);
  localparam int LYW  = $clog2(POY+1);
  localparam int LFW  = $clog2(POF+1);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_RUN, S_DONE} state_t;

  state_t             r_state;
  logic               r_busy, r_done, r_err, r_valid;
  logic [DIM_W-1:0]   r_nif, r_nof, r_nox, r_noy, r_nix, r_nkx, r_nky, r_s;
  logic [DIM_W-1:0]   r_of_t, r_oy_t, r_ox_t, r_ni, r_ky, r_kx;
  logic [ADDR_W-1:0]  r_ifm, r_wgt, r_ofm;
  logic               r_first, r_last;
  logic [LXW-1:0]     r_lane_ox;
  logic [LYW-1:0]     r_lane_oy;
  logic [LFW-1:0]     r_lane_of;

  logic               w_accept, w_final, w_load, w_cfg_bad;
  logic               w_kx_last, w_ky_last, w_ni_last, w_ox_last, w_oy_last, w_of_last;
  logic [DIM_W-1:0]   w_n_of, w_n_oy, w_n_ox, w_n_ni, w_n_ky, w_n_kx;
  logic [WIDE-1:0]    w_of_base, w_oy_base, w_ox_base;
  logic [WIDE-1:0]    w_niy, w_iy, w_ix;
  logic [WIDE-1:0]    w_rem_ox, w_rem_oy, w_rem_of;
  logic [ADDR_W-1:0]  w_ifm, w_wgt, w_ofm;
  logic               w_first, w_last;
  logic [LXW-1:0]     w_lane_ox;
  logic [LYW-1:0]     w_lane_oy;
  logic [LFW-1:0]     w_lane_of;

`ifdef ZERO_PAD_EN
  logic [DIM_W-1:0]   r_pad;
  logic               r_pz;
  logic signed [WIDE:0] w_iy_s, w_ix_s, w_niy_s;
  logic               w_pz;
`else
  logic               w_unused_pad;
  assign w_unused_pad = ^cfg_pad;
`endif

  assign w_accept  = (r_state == S_RUN) && r_valid && out_ready;

  // Last-iteration flags of the current counter state.
  assign w_kx_last = (r_kx == r_nkx - DIM_W'(1));
  assign w_ky_last = (r_ky == r_nky - DIM_W'(1));
  assign w_ni_last = (r_ni == r_nif - DIM_W'(1));
  assign w_ox_last = (WIDE'(r_ox_t) * WIDE'(POX) + WIDE'(POX)) >= WIDE'(r_nox);
  assign w_oy_last = (WIDE'(r_oy_t) * WIDE'(POY) + WIDE'(POY)) >= WIDE'(r_noy);
  assign w_of_last = (WIDE'(r_of_t) * WIDE'(POF) + WIDE'(POF)) >= WIDE'(r_nof);
  assign w_final   = w_kx_last && w_ky_last && w_ni_last &&
                     w_ox_last && w_oy_last && w_of_last;

`ifdef ZERO_PAD_EN
  assign w_cfg_bad = (r_nif == '0) || (r_nof == '0) || (r_nox == '0) ||
                     (r_noy == '0) || (r_nkx == '0) || (r_nky == '0) ||
                     (r_s == '0) || (r_pad >= r_nkx) || (r_pad >= r_nky);
`else
  assign w_cfg_bad = (r_nif == '0) || (r_nof == '0) || (r_nox == '0) ||
                     (r_noy == '0) || (r_nkx == '0) || (r_nky == '0) ||
                     (r_s == '0);
`endif

  assign w_load = ((r_state == S_CHECK) && !w_cfg_bad) || w_accept;

  // Next counter state: cleared in CHECK, ripple-carry increment on accept.
  // On the final beat the counters hold so the outputs stay stable into DONE.
  always_comb begin
    w_n_of = r_of_t;
    w_n_oy = r_oy_t;
    w_n_ox = r_ox_t;
    w_n_ni = r_ni;
    w_n_ky = r_ky;
    w_n_kx = r_kx;
    if (r_state == S_CHECK) begin
      w_n_of = '0;
      w_n_oy = '0;
      w_n_ox = '0;
      w_n_ni = '0;
      w_n_ky = '0;
      w_n_kx = '0;
    end else if (w_accept && !w_final) begin
      if (!w_kx_last) begin
        w_n_kx = r_kx + DIM_W'(1);
      end else begin
        w_n_kx = '0;
        if (!w_ky_last) begin
          w_n_ky = r_ky + DIM_W'(1);
        end else begin
          w_n_ky = '0;
          if (!w_ni_last) begin
            w_n_ni = r_ni + DIM_W'(1);
          end else begin
            w_n_ni = '0;
            if (!w_ox_last) begin
              w_n_ox = r_ox_t + DIM_W'(1);
            end else begin
              w_n_ox = '0;
              if (!w_oy_last) begin
                w_n_oy = r_oy_t + DIM_W'(1);
              end else begin
                w_n_oy = '0;
                w_n_of = r_of_t + DIM_W'(1);
              end
            end
          end
        end
      end
    end
  end

  // Beat fields derived from the next counter state; registered on w_load.
  always_comb begin
    w_of_base = WIDE'(w_n_of) * WIDE'(POF);
    w_oy_base = WIDE'(w_n_oy) * WIDE'(POY);
    w_ox_base = WIDE'(w_n_ox) * WIDE'(POX);
    w_niy     = WIDE'(r_noy - DIM_W'(1)) * WIDE'(r_s) + WIDE'(r_nky);
    w_iy      = WIDE'(r_s) * w_oy_base + WIDE'(w_n_ky);
    w_ix      = WIDE'(r_s) * w_ox_base + WIDE'(w_n_kx);
`ifdef ZERO_PAD_EN
    // Shift by -pad in signed space; the real input map is 2*pad smaller
    // than the padded window span.
    w_iy_s  = $signed({1'b0, w_iy}) - $signed({1'b0, WIDE'(r_pad)});
    w_ix_s  = $signed({1'b0, w_ix}) - $signed({1'b0, WIDE'(r_pad)});
    w_niy_s = $signed({1'b0, w_niy}) - $signed({1'b0, WIDE'(r_pad)})
              - $signed({1'b0, WIDE'(r_pad)});
    w_pz    = w_iy_s[WIDE] || (w_iy_s >= w_niy_s) ||
              w_ix_s[WIDE] || (w_ix_s >= $signed({1'b0, WIDE'(r_nix)}));
    w_ifm   = w_pz ? '0 :
              ADDR_W'((WIDE'(w_n_ni) * w_niy_s[WIDE-1:0] + w_iy_s[WIDE-1:0])
                      * WIDE'(r_nix) + w_ix_s[WIDE-1:0]);
`else
    w_ifm   = ADDR_W'((WIDE'(w_n_ni) * w_niy + w_iy) * WIDE'(r_nix) + w_ix);
`endif
    w_wgt   = ADDR_W'(((WIDE'(w_n_of) * WIDE'(r_nif) + WIDE'(w_n_ni))
                       * WIDE'(r_nky) + WIDE'(w_n_ky)) * WIDE'(r_nkx) + WIDE'(w_n_kx));
    w_ofm   = ADDR_W'((w_of_base * WIDE'(r_noy) + w_oy_base) * WIDE'(r_nox) + w_ox_base);
    w_first = (w_n_ni == '0) && (w_n_ky == '0) && (w_n_kx == '0);
    w_last  = (w_n_ni == r_nif - DIM_W'(1)) && (w_n_ky == r_nky - DIM_W'(1)) &&
              (w_n_kx == r_nkx - DIM_W'(1));
    w_rem_ox  = WIDE'(r_nox) - w_ox_base;
    w_rem_oy  = WIDE'(r_noy) - w_oy_base;
    w_rem_of  = WIDE'(r_nof) - w_of_base;
    w_lane_ox = (w_rem_ox > WIDE'(POX)) ? LXW'(POX) : LXW'(w_rem_ox);
    w_lane_oy = (w_rem_oy > WIDE'(POY)) ? LYW'(POY) : LYW'(w_rem_oy);
    w_lane_of = (w_rem_of > WIDE'(POF)) ? LFW'(POF) : LFW'(w_rem_of);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_valid   <= 1'b0;
      r_nif     <= '0;
      r_nof     <= '0;
      r_nox     <= '0;
      r_noy     <= '0;
      r_nix     <= '0;
      r_nkx     <= '0;
      r_nky     <= '0;
      r_s       <= '0;
      r_of_t    <= '0;
      r_oy_t    <= '0;
      r_ox_t    <= '0;
      r_ni      <= '0;
      r_ky      <= '0;
      r_kx      <= '0;
      r_ifm     <= '0;
      r_wgt     <= '0;
      r_ofm     <= '0;
      r_first   <= 1'b0;
      r_last    <= 1'b0;
      r_lane_ox <= '0;
      r_lane_oy <= '0;
      r_lane_of <= '0;
`ifdef ZERO_PAD_EN
      r_pad     <= '0;
      r_pz      <= 1'b0;
`endif
    end else begin
      r_of_t <= w_n_of;
      r_oy_t <= w_n_oy;
      r_ox_t <= w_n_ox;
      r_ni   <= w_n_ni;
      r_ky   <= w_n_ky;
      r_kx   <= w_n_kx;
      if (w_load) begin
        r_ifm     <= w_ifm;
        r_wgt     <= w_wgt;
        r_ofm     <= w_ofm;
        r_first   <= w_first;
        r_last    <= w_last;
        r_lane_ox <= w_lane_ox;
        r_lane_oy <= w_lane_oy;
        r_lane_of <= w_lane_of;
`ifdef ZERO_PAD_EN
        r_pz      <= w_pz;
`endif
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_nif   <= cfg_nif;
            r_nof   <= cfg_nof;
            r_nox   <= cfg_nox;
            r_noy   <= cfg_noy;
            r_nix   <= cfg_nix;
            r_nkx   <= cfg_nkx;
            r_nky   <= cfg_nky;
            r_s     <= cfg_s;
`ifdef ZERO_PAD_EN
            r_pad   <= cfg_pad;
`endif
            r_busy  <= 1'b1;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_cfg_bad) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_valid <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_accept && w_final) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign cfg_err   = r_err;
  assign out_valid = r_valid;
  assign ifm_addr  = r_ifm;
  assign wgt_addr  = r_wgt;
  assign ofm_addr  = r_ofm;
  assign acc_first = r_first;
  assign acc_last  = r_last;
  assign lane_ox   = r_lane_ox;
  assign lane_oy   = r_lane_oy;
  assign lane_of   = r_lane_of;
`ifdef ZERO_PAD_EN
  assign pad_zero  = r_pz;
`endif

endmodule

// File: doc/conv_loop_sequencer.md
Name: conv_loop_sequencer

Overview:
- Runtime-configurable loop-nest sequencer for the convolution datapath. Walks the tiled output loops (Nof/POF, Noy/POY, Nox/POX) and the accumulated loops (Nif, Nky, Nkx).
- Streams one address/control beat per accepted handshake to the input-FM buffer, the weight buffer and a POF x POY x POX MAC array.
- Flags accumulator clear and writeback.
- Handles edge tiles, stride and invalid configuration.

Parameters:
DIM_W, 8, width of every cfg dimension input
ADDR_W, 16, width of generated buffer addresses
POF, 8, output-channel parallelism of MAC array
POY, 14, output-row parallelism
POX, 14, output-column parallelism

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse: latch cfg_* and begin sequencing
cfg_nif, cfg_nof, cfg_nox, cfg_noy, cfg_nix, cfg_nkx, cfg_nky, cfg_s  in  DIM_W each  layer dimensions, stride
cfg_pad  in  DIM_W  zero-padding amount (used only with ZERO_PAD_EN)
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at end of layer or on config error
cfg_err  out  1  registered with done; high if config rejected
out_valid  out  1  beat valid
out_ready  in  1  downstream accepts beat
ifm_addr  out  ADDR_W  ((ni*Niy+iy)*cfg_nix+ix), with iy=S*oy_base+ky, ix=S*ox_base+kx
wgt_addr  out  ADDR_W  ((of_t*Nif+ni)*Nky+ky)*Nkx+kx
ofm_addr  out  ADDR_W  (of_t*POF*Noy+oy_base)*Nox+ox_base
acc_first  out  1  first beat of a tile (ni=ky=kx=0): MACs load instead of accumulate
acc_last  out  1  last beat of a tile: MACs write back to ofm_addr
lane_ox, lane_oy  out  $clog2(POX+1), $clog2(POY+1)  valid lanes in tile = min(P, N-base)
lane_of  out  $clog2(POF+1)  valid output channels in tile

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, cfg_err=0, out_valid=0. All counters and address outputs 0.
- Niy is derived: (cfg_noy-1)*cfg_s+cfg_nky.
- States:
  - IDLE: start=1 -> CHECK. Config is latched in the same cycle.
  - CHECK (1 cycle): any of nif/nof/nox/noy/nkx/nky/s equal to 0 -> DONE with cfg_err=1, no beats issued. Otherwise RUN and busy=1.
  - RUN: out_valid=1. Counters advance only on out_valid&&out_ready. Nesting, outer to inner: of_t, oy_t, ox_t, ni, ky, kx. After the final beat is accepted -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Tile counts are ceil(N/P). Bases are of_t*POF, oy_t*POY, ox_t*POX.
- Beat outputs are registered from the counter state. A new beat appears the cycle after acceptance, so throughput is 1 beat/cycle under continuous ready.
- Backpressure: while out_valid=1 and out_ready=0, every beat output is held stable.
- start while busy is ignored. start in the same cycle as DONE is ignored.
- Arithmetic is unsigned with ADDR_W truncation. The implementation must not overflow intermediate products narrower than 2*DIM_W+ADDR_W.
- Total beats = tiles_of*tiles_oy*tiles_ox*Nif*Nky*Nkx.
- When Nif=Nky=Nkx=1, acc_first and acc_last are both high on every beat.
- rst_n low mid-RUN aborts immediately with no done pulse.

Optional Feature:
- Macro ZERO_PAD_EN.
- With it: iy and ix are offset by -cfg_pad and computed signed. Extra output pad_zero (1 bit) is high when iy<0, iy>=Niy+... or ix<0, ix>=cfg_nix, i.e. outside the unpadded map. ifm_addr is forced to 0 on those beats and the MAC array must use operand 0.
- CHECK additionally rejects cfg_pad>=cfg_nkx or cfg_pad>=cfg_nky.
- Without it: cfg_pad is ignored, no pad_zero port, Niy unpadded.

Test Plan:
- Zero dimension: cfg_nkx=0, start -> no out_valid; done and cfg_err high together 2 cycles after start.
- Full layer: Nif=2, Nof=16, Nox=Noy=28, Nkx=Nky=3, S=1, out_ready=1 -> exactly 144 beats.
  - acc_last on beats 18, 36, …, 144.
  - First wgt_addr sequence 0..17.
  - ofm_addr of tile 2 is 14.
  - done one cycle after the last beat.
- Backpressure: toggle out_ready randomly during the full-layer case -> beat sequence is identical to the ready=1 run. Outputs are stable during every stall.
- Edge tile: Nox=Noy=20, Nof=5, Nif=Nkx=Nky=1 -> 4 beats, all with acc_first=acc_last=1.
  - lane_ox = 14, 6, 14, 6.
  - lane_oy = 14, 14, 6, 6.
  - lane_of = 5 on all four beats.
- Stride: S=2, Nix=57, Nox=28, Nkx=Nky=3, Nif=1 -> beat (ox_t=1, ky=0, kx=1) has ifm_addr 29.
- Reset abort: assert rst_n=0 mid-RUN -> next cycle busy=0, out_valid=0, no done pulse. A new start runs the full sequence from beat 0.
- ZERO_PAD_EN: pad=1, Nkx=Nky=3, S=1 -> first beat has pad_zero=1 and ifm_addr=0. Beat ky=1, kx=1 has pad_zero=0 and ifm_addr=0.
